reg_bus_sequencer: RTL and testbench

Controller that sequences register-to-register transfers over the dual 8-bit buses (BUSA/BUSB) of the CPU register bank. It takes transfer or increment commands from two requesters, port 0 (control unit) and port 1 (debug/DMA), and arbitrates them round-robin. Each granted command is converted into a glitch-free, multi-cycle strobe sequence (enable, latch, inc, bus selects) that drives NUM_REGS dual-bus 8-bit registers.

---
 rtl/reg_bus_sequencer.sv | 253 +++++++++++++++++++++++++
 tb/tb_reg_bus_sequencer.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bus_sequencer.sv
// reg_bus_sequencer: arbitrates transfer/increment commands from two requesters
// and sequences the strobes of a bank of dual-bus 8-bit registers.
// Latency: transfer grant T -> done T+3 (next grant T+4); inc grant T -> done T+1.
// Backpressure: reqN_ready is high only in IDLE for the granted port; callers hold
// valid and stable fields until ready.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   reqN_valid/ready            command handshake, N = 0 (control unit), 1 (debug/DMA)
//   reqN_src/dst/bus/inc        source index, destination index, bus (0=A,1=B), inc-only flag
//   reg_enable/latch/inc        one-hot register strobes (registered)
//   reg_in_sel/reg_out_sel      per-register bus selects (registered)
//   busy, done, done_port, error  status; done/error are single-cycle pulses
//
// Build option: define SEQ_FIXED_PRIORITY_EN to make port 0 win every tie
// (no round-robin pointer). Default build is round-robin.

module reg_bus_sequencer #(
  parameter int NUM_REGS = 8,
  parameter int IDX_W    = 3
) (
  input  logic                clk,
  input  logic                reset,

  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [IDX_W-1:0]    req0_src,
  input  logic [IDX_W-1:0]    req0_dst,
  input  logic                req0_bus,
  input  logic                req0_inc,

  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [IDX_W-1:0]    req1_src,
  input  logic [IDX_W-1:0]    req1_dst,
  input  logic                req1_bus,
  input  logic                req1_inc,

  output logic [NUM_REGS-1:0] reg_enable,
  output logic [NUM_REGS-1:0] reg_latch,
  output logic [NUM_REGS-1:0] reg_inc,
  output logic [NUM_REGS-1:0] reg_in_sel,
  output logic [NUM_REGS-1:0] reg_out_sel,
  output logic                busy,
  output logic                done,
  output logic                done_port,
  output logic                error
);

  // One extra bit so NUM_REGS itself is representable for the range check.
  localparam logic [IDX_W:0]    NUM_REGS_W = (IDX_W+1)'(NUM_REGS);
  localparam logic [NUM_REGS-1:0] ONE      = NUM_REGS'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DRIVE = 3'd1,
    S_LATCH = 3'd2,
    S_HOLD  = 3'd3,
    S_INC   = 3'd4
  } state_t;

  state_t state_q, state_d;

  // Registered command of the current grant.
  logic [IDX_W-1:0] src_q, src_d;
  logic [IDX_W-1:0] dst_q, dst_d;
  logic             bus_q, bus_d;
  logic             port_q, port_d;

  // Registered outputs.
  logic [NUM_REGS-1:0] enable_q, enable_d;
  logic [NUM_REGS-1:0] latch_q, latch_d;
  logic [NUM_REGS-1:0] inc_q, inc_d;
  logic [NUM_REGS-1:0] in_sel_q, in_sel_d;
  logic [NUM_REGS-1:0] out_sel_q, out_sel_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                error_q, error_d;

  // Arbitration.
  logic             gnt_vld;
  logic             gnt_port;
  logic [IDX_W-1:0] sel_src;
  logic [IDX_W-1:0] sel_dst;
  logic             sel_bus;
  logic             sel_inc;
  logic             sel_bad;

`ifdef SEQ_FIXED_PRIORITY_EN
  // Port 1 only ever wins when port 0 is idle.
  always_comb begin
    gnt_port = ~req0_valid;
  end
`else
  logic rr_q, rr_d;   // port that wins the next tie

  always_comb begin
    if (req0_valid && req1_valid) begin
      gnt_port = rr_q;
    end else begin
      gnt_port = ~req0_valid;
    end
  end

  always_comb begin
    rr_d = rr_q;
    if (gnt_vld) begin
      rr_d = ~gnt_port;   // a rejected command still consumes its turn
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_q <= 1'b0;
    end else begin
      rr_q <= rr_d;
    end
  end
`endif

  // Grants are blocked during reset so nothing is accepted while the bank is aborting.
  assign gnt_vld    = ~reset && (state_q == S_IDLE) && (req0_valid || req1_valid);
  assign req0_ready = gnt_vld & ~gnt_port;
  assign req1_ready = gnt_vld &  gnt_port;

  assign sel_src = gnt_port ? req1_src : req0_src;
  assign sel_dst = gnt_port ? req1_dst : req0_dst;
  assign sel_bus = gnt_port ? req1_bus : req0_bus;
  assign sel_inc = gnt_port ? req1_inc : req0_inc;

  // An increment only touches dst, so src is not range-checked for it.
  assign sel_bad = ({1'b0, sel_dst} >= NUM_REGS_W) ||
                   (~sel_inc && (({1'b0, sel_src} >= NUM_REGS_W) || (sel_src == sel_dst)));

  // Next-state and command capture.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    bus_d   = bus_q;
    port_d  = port_q;
    error_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (gnt_vld) begin
          src_d  = sel_src;
          dst_d  = sel_dst;
          bus_d  = sel_bus;
          port_d = gnt_port;
          if (sel_bad) begin
            error_d = 1'b1;
          end else if (sel_inc) begin
            state_d = S_INC;
          end else begin
            state_d = S_DRIVE;
          end
        end
      end
      S_DRIVE: state_d = S_LATCH;
      S_LATCH: state_d = S_HOLD;
      S_HOLD:  state_d = S_IDLE;
      S_INC:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes are decoded from the state being entered and loaded into flops, so the
  // outputs change only on the clock edge and never glitch on request activity.
  always_comb begin
    logic [NUM_REGS-1:0] src_oh;
    logic [NUM_REGS-1:0] dst_oh;
    src_oh    = ONE << src_d;
    dst_oh    = ONE << dst_d;
    enable_d  = '0;
    latch_d   = '0;
    inc_d     = '0;
    in_sel_d  = '0;
    out_sel_d = '0;
    case (state_d)
      S_DRIVE, S_HOLD: begin
        enable_d  = src_oh;
        out_sel_d = bus_d ? src_oh : '0;
        in_sel_d  = bus_d ? dst_oh : '0;
      end
      S_LATCH: begin
        enable_d  = src_oh;
        out_sel_d = bus_d ? src_oh : '0;
        in_sel_d  = bus_d ? dst_oh : '0;
        latch_d   = dst_oh;
      end
      S_INC: begin
        inc_d = dst_oh;
      end
      default: begin
      end
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_HOLD) || (state_d == S_INC);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      bus_q     <= 1'b0;
      port_q    <= 1'b0;
      enable_q  <= '0;
      latch_q   <= '0;
      inc_q     <= '0;
      in_sel_q  <= '0;
      out_sel_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      bus_q     <= bus_d;
      port_q    <= port_d;
      enable_q  <= enable_d;
      latch_q   <= latch_d;
      inc_q     <= inc_d;
      in_sel_q  <= in_sel_d;
      out_sel_q <= out_sel_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  assign reg_enable  = enable_q;
  assign reg_latch   = latch_q;
  assign reg_inc     = inc_q;
  assign reg_in_sel  = in_sel_q;
  assign reg_out_sel = out_sel_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign done_port   = port_q;   // holds the last granted port, valid with done/error
  assign error       = error_q;

  // Strobe sanity: one driver on the bus, one latch or inc at a time.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert ($onehot0(enable_q));
      assert ($onehot0(latch_q));
      assert ($onehot0(inc_q));
      assert ((latch_q & inc_q) == '0);
    end
  end

endmodule

// File: tb/tb_reg_bus_sequencer.sv
module tb_reg_bus_sequencer;
  localparam int NR = 8;
  localparam int IW = 4;

  logic clk = 1'b0;
  logic reset;
  logic req0_valid, req0_ready, req0_bus, req0_inc;
  logic [IW-1:0] req0_src, req0_dst;
  logic req1_valid, req1_ready, req1_bus, req1_inc;
  logic [IW-1:0] req1_src, req1_dst;
  logic [NR-1:0] reg_enable, reg_latch, reg_inc, reg_in_sel, reg_out_sel;
  logic busy, done, done_port, error;

  always #5 clk = ~clk;

  reg_bus_sequencer #(.NUM_REGS(NR), .IDX_W(IW)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_src(req0_src),
    .req0_dst(req0_dst), .req0_bus(req0_bus), .req0_inc(req0_inc),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_src(req1_src),
    .req1_dst(req1_dst), .req1_bus(req1_bus), .req1_inc(req1_inc),
    .reg_enable(reg_enable), .reg_latch(reg_latch), .reg_inc(reg_inc),
    .reg_in_sel(reg_in_sel), .reg_out_sel(reg_out_sel),
    .busy(busy), .done(done), .done_port(done_port), .error(error)
  );

  typedef struct packed {
    logic [IW-1:0] src;
    logic [IW-1:0] dst;
    logic          bus;
    logic          inc;
  } cmd_t;

  typedef struct {
    int kind;   // 0 = done, 1 = error
    int port;
    int due;
  } rsp_t;

  cmd_t cq0[$], cq1[$];
  cmd_t cur0, cur1;
  rsp_t exp_q[$];
  int   gnt_log[$];

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  bit chk_en = 0;
  bit gap_mode = 0;
  bit cons0 = 0, cons1 = 0;

  // Reference model state: expected strobes per future cycle (ring), when the
  // sequencer is next free to grant, and whose turn a tie is.
  logic [NR-1:0] r_en[8], r_lat[8], r_inc[8], r_is[8], r_os[8];
  bit   r_busy[8];
  int   free_at = 0;
  int   rr = 0;

  task automatic clear_ring();
    for (int k = 0; k < 8; k++) begin
      r_en[k] = '0; r_lat[k] = '0; r_inc[k] = '0; r_is[k] = '0; r_os[k] = '0; r_busy[k] = 0;
    end
  endtask

  task automatic monitor_step();
    int s;
    rsp_t r;
    s = cyc % 8;
    n_cmp++;
    if ({reg_enable, reg_latch, reg_inc, reg_in_sel, reg_out_sel} !==
        {r_en[s], r_lat[s], r_inc[s], r_is[s], r_os[s]}) begin
      n_fail++;
      $display("FAIL strobes cyc=%0d: got en=%h lat=%h inc=%h is=%h os=%h want en=%h lat=%h inc=%h is=%h os=%h",
               cyc, reg_enable, reg_latch, reg_inc, reg_in_sel, reg_out_sel,
               r_en[s], r_lat[s], r_inc[s], r_is[s], r_os[s]);
    end
    n_cmp++;
    if (busy !== r_busy[s]) begin
      n_fail++;
      $display("FAIL busy cyc=%0d: got %b want %b", cyc, busy, r_busy[s]);
    end
    n_cmp++;
    if (!$onehot0(reg_enable) || !$onehot0(reg_latch) || !$onehot0(reg_inc) ||
        ((reg_latch & reg_inc) != '0)) begin
      n_fail++;
      $display("FAIL onehot cyc=%0d: got en=%h lat=%h inc=%h want at most one bit each, latch/inc disjoint",
               cyc, reg_enable, reg_latch, reg_inc);
    end
    r_en[s] = '0; r_lat[s] = '0; r_inc[s] = '0; r_is[s] = '0; r_os[s] = '0; r_busy[s] = 0;

    if (done === 1'b1 || error === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse cyc=%0d: got done=%b error=%b want none", cyc, done, error);
      end else begin
        r = exp_q.pop_front();
        if (done !== (r.kind == 0) || error !== (r.kind == 1) ||
            done_port !== r.port[0] || r.due != cyc) begin
          n_fail++;
          $display("FAIL completion cyc=%0d: got done=%b error=%b port=%b want kind=%0d port=%0d at cyc %0d",
                   cyc, done, error, done_port, r.kind, r.port, r.due);
        end
      end
    end else if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      n_cmp++;
      n_fail++;
      r = exp_q.pop_front();
      $display("FAIL missed_pulse cyc=%0d: got none want kind=%0d port=%0d", cyc, r.kind, r.port);
    end
  endtask

  task automatic model_step();
    int   g;
    cmd_t c;
    bit   bad;
    logic [NR-1:0] oh_s, oh_d;
    rsp_t r;
    g = -1;
    if (reset !== 1'b1 && cyc >= free_at) begin
      if (req0_valid && req1_valid) begin
`ifdef SEQ_FIXED_PRIORITY_EN
        g = 0;
`else
        g = rr;
`endif
      end else if (req0_valid) begin
        g = 0;
      end else if (req1_valid) begin
        g = 1;
      end
    end
    n_cmp++;
    if (req0_ready !== (g == 0) || req1_ready !== (g == 1)) begin
      n_fail++;
      $display("FAIL ready cyc=%0d: got r0=%b r1=%b want r0=%b r1=%b",
               cyc, req0_ready, req1_ready, (g == 0), (g == 1));
    end
    if (reset === 1'b1) begin
      // Anything in flight is aborted silently; the sequencer is idle afterwards.
      exp_q.delete();
      clear_ring();
      rr = 0;
      free_at = cyc + 1;
    end else if (g >= 0) begin
      c = (g == 0) ? cur0 : cur1;
      if (g == 0) cons0 = 1; else cons1 = 1;
      gnt_log.push_back(g);
      rr = 1 - g;
      bad = (int'(c.dst) >= NR) || (!c.inc && (int'(c.src) >= NR || c.src == c.dst));
      oh_s = NR'(1) << c.src;
      oh_d = NR'(1) << c.dst;
      r.port = g;
      if (bad) begin
        r.kind = 1; r.due = cyc + 1; free_at = cyc + 1;
      end else if (c.inc) begin
        r.kind = 0; r.due = cyc + 1; free_at = cyc + 2;
        r_inc[(cyc + 1) % 8] = oh_d;
        r_busy[(cyc + 1) % 8] = 1;
      end else begin
        r.kind = 0; r.due = cyc + 3; free_at = cyc + 4;
        for (int k = 1; k <= 3; k++) begin
          r_en[(cyc + k) % 8] = oh_s;
          r_os[(cyc + k) % 8] = c.bus ? oh_s : '0;
          r_is[(cyc + k) % 8] = c.bus ? oh_d : '0;
          r_busy[(cyc + k) % 8] = 1;
        end
        r_lat[(cyc + 2) % 8] = oh_d;
      end
      exp_q.push_back(r);
    end
  endtask

  // Driver + monitor + model, all stepping once per cycle on the falling edge.
  initial begin
    clear_ring();
    forever begin
      @(negedge clk);
      cyc++;
      if (cons0) begin req0_valid = 0; cons0 = 0; end
      if (cons1) begin req1_valid = 0; cons1 = 0; end
      if (!req0_valid && cq0.size() > 0 && (!gap_mode || $urandom_range(0, 2) != 0)) begin
        cur0 = cq0.pop_front();
        req0_src = cur0.src; req0_dst = cur0.dst; req0_bus = cur0.bus; req0_inc = cur0.inc;
        req0_valid = 1;
      end
      if (!req1_valid && cq1.size() > 0 && (!gap_mode || $urandom_range(0, 2) != 0)) begin
        cur1 = cq1.pop_front();
        req1_src = cur1.src; req1_dst = cur1.dst; req1_bus = cur1.bus; req1_inc = cur1.inc;
        req1_valid = 1;
      end
      #1;
      if (chk_en) monitor_step();
      model_step();
    end
  end

  function automatic cmd_t mk(int s, int d, int b, int i);
    cmd_t c;
    c.src = IW'(s); c.dst = IW'(d); c.bus = b[0]; c.inc = i[0];
    return c;
  endfunction

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while ((cq0.size() > 0 || cq1.size() > 0 || req0_valid || req1_valid || exp_q.size() > 0) && t < 4000) begin
      @(posedge clk);
      t++;
    end
    if (t >= 4000) begin
      n_cmp++;
      n_fail++;
      $display("FAIL timeout_%s: got still pending after %0d cycles want drained", name, t);
    end
    repeat (3) @(posedge clk);
  endtask

  initial begin
    int base;
    int t;
    int exp_ord[6];
    cmd_t c;

    reset = 1;
    req0_valid = 0; req0_src = '0; req0_dst = '0; req0_bus = 0; req0_inc = 0;
    req1_valid = 0; req1_src = '0; req1_dst = '0; req1_bus = 0; req1_inc = 0;
    repeat (3) @(negedge clk);
    chk_en = 1;
    #2;
    n_cmp++;
    if ({reg_enable, reg_latch, reg_inc, reg_in_sel, reg_out_sel, busy, done, error, done_port,
         req0_ready, req1_ready} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got en=%h lat=%h inc=%h busy=%b done=%b err=%b want all zero",
               reg_enable, reg_latch, reg_inc, busy, done, error);
    end
    @(negedge clk);
    reset = 0;

    // Single transfer, inc, then back-to-back contention.
    cq0.push_back(mk(2, 5, 0, 0));
    wait_drain("xfer");
    cq1.push_back(mk(0, 7, 0, 1));
    wait_drain("inc");

    base = gnt_log.size();
    for (int k = 0; k < 3; k++) begin
      cq0.push_back(mk(k, k + 4, k % 2, 0));
      cq1.push_back(mk(k + 4, k, 1, 0));
    end
`ifdef SEQ_FIXED_PRIORITY_EN
    exp_ord = '{0, 0, 0, 1, 1, 1};
`else
    exp_ord = '{0, 1, 0, 1, 0, 1};
`endif
    wait_drain("contend");
    for (int k = 0; k < 6; k++) begin
      n_cmp++;
      if (gnt_log.size() <= base + k || gnt_log[base + k] != exp_ord[k]) begin
        n_fail++;
        $display("FAIL grant_order[%0d]: got %0d want %0d", k,
                 (gnt_log.size() > base + k) ? gnt_log[base + k] : -1, exp_ord[k]);
      end
    end

    // Rejects: src==dst transfer, src out of range.
    cq0.push_back(mk(3, 3, 0, 0));
    cq0.push_back(mk(9, 1, 1, 0));
    cq1.push_back(mk(0, 8, 0, 1));
    wait_drain("reject");

    // Reset while the transfer sits in LATCH.
    base = gnt_log.size();
    cq0.push_back(mk(1, 6, 1, 0));
    t = 0;
    while (gnt_log.size() == base && t < 100) begin
      @(posedge clk);
      t++;
    end
    n_cmp++;
    if (t >= 100) begin
      n_fail++;
      $display("FAIL grant_before_reset: got no grant want grant");
    end
    @(negedge clk);   // DRIVE cycle
    @(negedge clk);   // LATCH cycle
    reset = 1;
    @(negedge clk);
    reset = 0;
    #2;
    n_cmp++;
    if ({reg_enable, reg_latch, reg_inc, reg_in_sel, reg_out_sel, busy, done, error} !== '0) begin
      n_fail++;
      $display("FAIL abort: got en=%h lat=%h is=%h os=%h busy=%b done=%b want all zero",
               reg_enable, reg_latch, reg_in_sel, reg_out_sel, busy, done);
    end
    cq0.push_back(mk(1, 6, 1, 0));
    wait_drain("after_reset");

    // Randomised traffic with gaps, including out-of-range indices.
    gap_mode = 1;
    for (int n = 0; n < 200; n++) begin
      c.inc = ($urandom_range(0, 3) == 0);
      c.bus = 1'($urandom_range(0, 1));
      c.dst = IW'($urandom_range(0, 9));
      c.src = c.inc ? IW'($urandom_range(0, NR - 1)) : IW'($urandom_range(0, 9));
      if ($urandom_range(0, 1) == 0) cq0.push_back(c);
      else cq1.push_back(c);
    end
    wait_drain("random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish before 50000 cycles");
    $fatal(1, "watchdog");
  end

endmodule
